// File: rtl/cursor_input_ctrl.sv
// Cursor controller for a square block grid: debounces five push buttons and
// moves a highlighted block with edge clamping; middle press emits a select pulse.
module cursor_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned GRID_SIZE       = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        middle,
  input  logic        lock,
  output logic [9:0]  x_topleft,
  output logic [8:0]  y_topleft,
  output logic [31:0] VGAid,
  output logic        pressed
);

  localparam int unsigned NBTN  = 5;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [9:0] X_MAX = 10'(GRID_SIZE);
  localparam logic [8:0] Y_MAX = 9'(GRID_SIZE);

  logic [NBTN-1:0]  raw;
  logic [NBTN-1:0]  sync1;
  logic [NBTN-1:0]  sync2;
  logic [NBTN-1:0]  level;
  logic [NBTN-1:0]  level_d;
  logic [NBTN-1:0]  rise;
  logic [CNT_W-1:0] cnt [NBTN];

  logic ev_up, ev_down, ev_left, ev_right, ev_mid;

  logic [9:0]  x_next;
  logic [8:0]  y_next;
  logic [31:0] vga_next;
  logic        pressed_next;

  assign raw = {middle, right, left, down, up};

  // Two-flop synchronizer on every raw button
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Accept a level only after DEBOUNCE_CYCLES consecutive mismatching samples
  always_ff @(posedge clk) begin
    if (reset) begin
      level   <= '0;
      level_d <= '0;
      for (int i = 0; i < int'(NBTN); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      level_d <= level;
      for (int i = 0; i < int'(NBTN); i++) begin
        if (sync2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          level[i] <= sync2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Press event is the debounced 0->1 transition only
  assign rise = level & ~level_d;
  assign {ev_mid, ev_right, ev_left, ev_down, ev_up} = rise;

  // One move per cycle, up > down > left > right, clamped to 1..GRID_SIZE
  always_comb begin
    x_next       = x_topleft;
    y_next       = y_topleft;
    pressed_next = 1'b0;
    if (!lock) begin
      if (ev_up) begin
        if (y_topleft > 9'd1) y_next = y_topleft - 9'd1;
      end else if (ev_down) begin
        if (y_topleft < Y_MAX) y_next = y_topleft + 9'd1;
      end else if (ev_left) begin
        if (x_topleft > 10'd1) x_next = x_topleft - 10'd1;
      end else if (ev_right) begin
        if (x_topleft < X_MAX) x_next = x_topleft + 10'd1;
      end
      pressed_next = ev_mid;
    end
    vga_next = 32'(y_next - 9'd1) * 32'(GRID_SIZE) + 32'(x_next - 10'd1);
  end

  // Index is computed from the next coordinates so it never lags them
  always_ff @(posedge clk) begin
    if (reset) begin
      x_topleft <= 10'd1;
      y_topleft <= 9'd1;
      VGAid     <= '0;
      pressed   <= 1'b0;
    end else begin
      x_topleft <= x_next;
      y_topleft <= y_next;
      VGAid     <= vga_next;
      pressed   <= pressed_next;
    end
  end

endmodule
